// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, one-cycle imem request pipeline and a 2-entry
// instruction queue feeding IF/ID. Optional halt detection is enabled by FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter int              AW       = 9,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          id_ready,
    output logic          if_valid,
    output logic [DW-1:0] if_inst,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_next,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          halted
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] inflight_pc;
    logic          inflight;
    logic [1:0]    count;
    logic [DW-1:0] q_inst [2];
    logic [AW-1:0] q_pc   [2];

    logic       pop;
    logic       push;
    logic       halt_hit;
    logic [2:0] occupancy;

    assign if_valid   = (count != 2'd0) && !redirect;
    assign if_inst    = q_inst[0];
    assign if_pc      = q_pc[0];
    assign if_pc_next = if_pc + {{(AW-1){1'b0}}, 1'b1};
    assign pop        = if_valid && id_ready;

    // Slots already committed (queued + returning) minus what leaves this cycle must stay below 2.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign imem_rd   = (state == RUN) && !redirect && (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = pc;

    // Responses returning while halted belong to the wrong side of the HALT and are dropped.
    assign push = inflight && !redirect && (state != HALT);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = push && (imem_data[DW-1 -: 3] == 3'b111);
    assign halted   = (state == HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            // NOTE: the queue storage is reset because its head drives if_inst/if_pc directly.
            q_inst[0]   <= '0;
            q_inst[1]   <= '0;
            q_pc[0]     <= '0;
            q_pc[1]     <= '0;
        end else if (redirect) begin
            state    <= RUN;
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= imem_rd;
            if (imem_rd) begin
                pc          <= pc + {{(AW-1){1'b0}}, 1'b1};
                inflight_pc <= pc;
            end

            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt_hit) state <= HALT;
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase

            case ({push, pop})
                2'b10: begin
                    q_inst[count[0]] <= imem_data;
                    q_pc[count[0]]   <= inflight_pc;
                    count            <= count + 2'd1;
                end
                2'b01: begin
                    q_inst[0] <= q_inst[1];
                    q_pc[0]   <= q_pc[1];
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_inst[0] <= imem_data;
                        q_pc[0]   <= inflight_pc;
                    end else begin
                        q_inst[0] <= q_inst[1];
                        q_pc[0]   <= q_pc[1];
                        q_inst[1] <= imem_data;
                        q_pc[1]   <= inflight_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count == 2'd2)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, streaming, stall, redirect, address wrap, halt and
// mid-stream reset, with hand-derived expectations per cycle.
module tb_fetch_stage;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          id_ready;
    logic          if_valid;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc_next;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;

    int checks   = 0;
    int failures = 0;
    logic halt_at_3 = 1'b0;

    fetch_stage #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc_next  (if_pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at a is A000+a, optionally a HALT opcode at address 3.
    always @(posedge clk) begin
        if (imem_rd) begin
            if (halt_at_3 && imem_addr == 9'd3) imem_data <= 16'hE000;
            else imem_data <= 16'hA000 + {7'd0, imem_addr};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        #12;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b expected 0", imem_rd); end
        checks++; if (imem_addr !== 9'd0) begin failures++; $display("FAIL reset_addr: got %h expected 000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (if_inst !== 16'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0000", if_inst); end
        checks++; if (if_pc !== 9'd0) begin failures++; $display("FAIL reset_pc: got %h expected 000", if_pc); end
        checks++; if (if_pc_next !== 9'd1) begin failures++; $display("FAIL reset_pc_next: got %h expected 001", if_pc_next); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    // Cycle k counted from reset release; k=0 is BOOT.
    task automatic test_sequential();
        cyc(); reset = 1'b1; #1;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL boot_rd: got %b expected 0", imem_rd); end
        for (int k = 1; k <= 7; k++) begin
            logic [AW-1:0] exp_addr;
            logic [AW-1:0] exp_pc;
            logic [DW-1:0] exp_inst;
            cyc(); #1;
            exp_addr = AW'(k - 1);
            checks++; if (imem_rd !== 1'b1 || imem_addr !== exp_addr) begin failures++;
                $display("FAIL seq_issue k=%0d: got rd=%b addr=%h expected rd=1 addr=%h", k, imem_rd, imem_addr, exp_addr); end
            if (k >= 3) begin
                exp_pc = AW'(k - 3);
                exp_inst = 16'hA000 + {7'd0, exp_pc};
                checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== exp_inst) begin failures++;
                    $display("FAIL seq_out k=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, if_valid, if_pc, if_inst, exp_pc, exp_inst); end
            end else begin
                checks++; if (if_valid !== 1'b0) begin failures++;
                    $display("FAIL seq_novalid k=%0d: got %b expected 0", k, if_valid); end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 8; k <= 15; k++) begin
            logic          exp_rd;
            logic [AW-1:0] exp_pc;
            cyc();
            id_ready = !(k >= 8 && k <= 11);
            #1;
            exp_rd = (k >= 12);
            exp_pc = (k < 12) ? 9'd5 : AW'(k - 7);
            checks++; if (imem_rd !== exp_rd || (exp_rd && imem_addr !== AW'(k - 5))) begin failures++;
                $display("FAIL stall_issue k=%0d: got rd=%b addr=%h expected rd=%b addr=%h", k, imem_rd, imem_addr, exp_rd, AW'(k - 5)); end
            checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin failures++;
                $display("FAIL stall_out k=%0d: got v=%b pc=%h expected v=1 pc=%h", k, if_valid, if_pc, exp_pc); end
        end
    endtask

    task automatic test_redirect();
        cyc(); id_ready = 1'b0; #1;
        checks++; if (imem_rd !== 1'b0 || if_pc !== 9'd9) begin failures++;
            $display("FAIL redir_fill: got rd=%b pc=%h expected rd=0 pc=009", imem_rd, if_pc); end
        cyc(); id_ready = 1'b1; redirect = 1'b1; redirect_pc = 9'h040; #1;
        checks++; if (if_valid !== 1'b0 || imem_rd !== 1'b0) begin failures++;
            $display("FAIL redir_cycle: got v=%b rd=%b expected v=0 rd=0", if_valid, imem_rd); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 9'h040 || if_valid !== 1'b0) begin failures++;
            $display("FAIL redir_t1: got rd=%b addr=%h v=%b expected rd=1 addr=040 v=0", imem_rd, imem_addr, if_valid); end
        cyc(); #1;
        checks++; if (imem_addr !== 9'h041 || if_valid !== 1'b0) begin failures++;
            $display("FAIL redir_t2: got addr=%h v=%b expected addr=041 v=0", imem_addr, if_valid); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h040 || if_inst !== 16'hA040) begin failures++;
            $display("FAIL redir_t3: got v=%b pc=%h inst=%h expected v=1 pc=040 inst=A040", if_valid, if_pc, if_inst); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h041) begin failures++;
            $display("FAIL redir_t4: got v=%b pc=%h expected v=1 pc=041", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
        cyc(); redirect = 1'b1; redirect_pc = 9'h1FE; #1;
        cyc(); redirect = 1'b0; #1;
        checks++; if (imem_addr !== 9'h1FE) begin failures++; $display("FAIL wrap_a1: got %h expected 1FE", imem_addr); end
        cyc(); #1;
        checks++; if (imem_addr !== 9'h1FF) begin failures++; $display("FAIL wrap_a2: got %h expected 1FF", imem_addr); end
        cyc(); #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 9'h000 || if_pc !== 9'h1FE) begin failures++;
            $display("FAIL wrap_a3: got rd=%b addr=%h pc=%h expected rd=1 addr=000 pc=1FE", imem_rd, imem_addr, if_pc); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h1FF || if_pc_next !== 9'h000 || if_inst !== 16'hA1FF) begin failures++;
            $display("FAIL wrap_top: got v=%b pc=%h next=%h inst=%h expected v=1 pc=1FF next=000 inst=A1FF", if_valid, if_pc, if_pc_next, if_inst); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h000 || if_pc_next !== 9'h001 || if_inst !== 16'hA000) begin failures++;
            $display("FAIL wrap_zero: got v=%b pc=%h next=%h inst=%h expected v=1 pc=000 next=001 inst=A000", if_valid, if_pc, if_pc_next, if_inst); end
    endtask

    task automatic test_halt();
        halt_at_3 = 1'b1;
        cyc(); redirect = 1'b1; redirect_pc = 9'h000; #1;
        cyc(); redirect = 1'b0; #1;
        cyc(); cyc(); cyc(); cyc(); #1;
        checks++; if (if_pc !== 9'd2 || imem_rd !== 1'b1 || imem_addr !== 9'd4 || halted !== 1'b0) begin failures++;
            $display("FAIL halt_pre: got pc=%h rd=%b addr=%h h=%b expected pc=002 rd=1 addr=004 h=0", if_pc, imem_rd, imem_addr, halted); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'd3 || if_inst !== 16'hE000) begin failures++;
            $display("FAIL halt_inst: got v=%b pc=%h inst=%h expected v=1 pc=003 inst=E000", if_valid, if_pc, if_inst); end
`ifdef FETCH_HALT_DETECT_EN
        checks++; if (halted !== 1'b1 || imem_rd !== 1'b0) begin failures++;
            $display("FAIL halt_set: got h=%b rd=%b expected h=1 rd=0", halted, imem_rd); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b0 || imem_rd !== 1'b0 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_drain: got v=%b rd=%b h=%b expected v=0 rd=0 h=1", if_valid, imem_rd, halted); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b0 || imem_rd !== 1'b0 || halted !== 1'b1) begin failures++;
            $display("FAIL halt_hold: got v=%b rd=%b h=%b expected v=0 rd=0 h=1", if_valid, imem_rd, halted); end
`else
        checks++; if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 9'd5) begin failures++;
            $display("FAIL nohalt_issue: got h=%b rd=%b addr=%h expected h=0 rd=1 addr=005", halted, imem_rd, imem_addr); end
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'd4 || if_inst !== 16'hA004) begin failures++;
            $display("FAIL nohalt_next: got v=%b pc=%h inst=%h expected v=1 pc=004 inst=A004", if_valid, if_pc, if_inst); end
        cyc(); #1;
`endif
        cyc(); redirect = 1'b1; redirect_pc = 9'h010; #1;
        checks++; if (if_valid !== 1'b0 || imem_rd !== 1'b0) begin failures++;
            $display("FAIL halt_redir: got v=%b rd=%b expected v=0 rd=0", if_valid, imem_rd); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 9'h010) begin failures++;
            $display("FAIL halt_resume: got h=%b rd=%b addr=%h expected h=0 rd=1 addr=010", halted, imem_rd, imem_addr); end
        halt_at_3 = 1'b0;
    endtask

    task automatic test_reset_midstream();
        cyc(); #1;
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h010) begin failures++;
            $display("FAIL mid_stream: got v=%b pc=%h expected v=1 pc=010", if_valid, if_pc); end
        cyc(); id_ready = 1'b0; #1;
        cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'h011 || imem_rd !== 1'b0) begin failures++;
            $display("FAIL mid_full: got v=%b pc=%h rd=%b expected v=1 pc=011 rd=0", if_valid, if_pc, imem_rd); end
        #1 reset = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_rd !== 1'b0 || imem_addr !== 9'd0 || if_pc !== 9'd0) begin failures++;
            $display("FAIL mid_reset: got v=%b rd=%b addr=%h pc=%h expected v=0 rd=0 addr=000 pc=000", if_valid, imem_rd, imem_addr, if_pc); end
        cyc(); reset = 1'b1; id_ready = 1'b1; #1;
        checks++; if (imem_rd !== 1'b0) begin failures++; $display("FAIL mid_boot: got rd=%b expected 0", imem_rd); end
        cyc(); #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 9'd0) begin failures++;
            $display("FAIL mid_refetch: got rd=%b addr=%h expected rd=1 addr=000", imem_rd, imem_addr); end
        cyc(); cyc(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 9'd0 || if_inst !== 16'hA000) begin failures++;
            $display("FAIL mid_first: got v=%b pc=%h inst=%h expected v=1 pc=000 inst=A000", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
